g_func_key_expansion: RTL and testbench

Implements the AES-128 key-schedule g() function: RotWord, then SubWord (AES S-box on each byte), then XOR of the round constant into the most significant byte. It sits inside the key-expansion datapath and is applied to the last word of each 4-word round key to produce the next round key. The result is registered with a one-cycle latency, and a valid flag accompanies it.

---
 rtl/g_func_key_expansion.sv | 85 ++++++++
 tb/tb_g_func_key_expansion.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/g_func_key_expansion.sv
// AES-128 key-schedule g() function: RotWord, SubWord, Rcon XOR.
// One registered result per cycle with an accompanying valid flag.
module g_func_key_expansion (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] inputWord,
    input  logic [3:0]  count,
    output logic [31:0] outputWord,
    output logic        out_valid
);

    // FIPS-197 forward S-box; index 0 is the leftmost byte of the first row.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd0:    r = 8'h01;
            4'd1:    r = 8'h02;
            4'd2:    r = 8'h04;
            4'd3:    r = 8'h08;
            4'd4:    r = 8'h10;
            4'd5:    r = 8'h20;
            4'd6:    r = 8'h40;
            4'd7:    r = 8'h80;
            4'd8:    r = 8'h1b;
            4'd9:    r = 8'h36;
            default: r = 8'h00;   // rounds 10..15 do not exist in AES-128
        endcase
        return r;
    endfunction

    logic [31:0] rot_word;
    logic [31:0] sub_word;
    logic [31:0] g_word;
    logic [31:0] out_word_d, out_word_q;
    logic        out_valid_d, out_valid_q;

    always_comb begin
        // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
        rot_word    = {inputWord[23:0], inputWord[31:24]};
        sub_word    = {sbox(rot_word[31:24]), sbox(rot_word[23:16]),
                       sbox(rot_word[15:8]),  sbox(rot_word[7:0])};
        g_word      = sub_word ^ {rcon(count), 24'h000000};
        out_valid_d = in_valid;
        out_word_d  = in_valid ? g_word : out_word_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            out_word_q  <= 32'h00000000;
            out_valid_q <= 1'b0;
        end else begin
            out_word_q  <= out_word_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign outputWord = out_word_q;
    assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_g_func_key_expansion.sv
// Self-checking bench for g_func_key_expansion: directed FIPS-197 vectors plus
// randomized traffic against a GF(2^8)-arithmetic reference model.
module tb_g_func_key_expansion;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] inputWord;
    logic [3:0]  count;
    logic [31:0] outputWord;
    logic        out_valid;

    int checks = 0;
    int errors = 0;

    logic [7:0] model_sbox [256];

    g_func_key_expansion dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .inputWord  (inputWord),
        .count      (count),
        .outputWord (outputWord),
        .out_valid  (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (field arithmetic, not a table) ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t = {b, b};
        return t[15-n -: 8];
    endfunction

    function automatic logic [7:0] sbox_math(input logic [7:0] a);
        logic [7:0] inv = 8'h00;
        if (a != 8'h00) begin
            inv = 8'h01;
            for (int i = 0; i < 254; i++) inv = gf_mul(inv, a);  // a^254 = a^-1
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon_ref(input int round);
        logic [7:0] r = 8'h01;
        if (round > 9) return 8'h00;
        for (int i = 0; i < round; i++) r = xtime(r);
        return r;
    endfunction

    function automatic logic [31:0] g_ref(input logic [31:0] w, input int round);
        logic [7:0] b [4];
        for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
        // rotate left by one byte: new byte3 = b2, byte2 = b1, byte1 = b0, byte0 = b3
        return {model_sbox[b[2]] ^ rcon_ref(round), model_sbox[b[1]],
                model_sbox[b[0]], model_sbox[b[3]]};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        checks++;
        if (outputWord !== 32'h00000000) begin
            errors++; $display("FAIL reset_async_word: got %h want 00000000", outputWord);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_async_valid: got %b want 0", out_valid);
        end
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk) #1;
            checks++;
            if (outputWord !== 32'h00000000 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle[%0d]: got %h/%b want 00000000/0", i, outputWord, out_valid);
            end
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        in_valid = 1'b1; inputWord = 32'h92BEB46D; count = 4'd0;
        @(posedge clk) #1;
        in_valid = 1'b0;
        checks++;
        if (outputWord !== 32'hAF8D3C4F || out_valid !== 1'b1) begin
            errors++; $display("FAIL single_result: got %h/%b want AF8D3C4F/1", outputWord, out_valid);
        end
        @(posedge clk) #1;
        checks++;
        if (outputWord !== 32'hAF8D3C4F || out_valid !== 1'b0) begin
            errors++; $display("FAIL single_hold: got %h/%b want AF8D3C4F/0", outputWord, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        in_valid = 1'b1; inputWord = 32'h09CF4F3C; count = 4'd0;
        @(posedge clk) #1;
        inputWord = 32'h2A6C7605; count = 4'd1;
        checks++;
        if (outputWord !== 32'h8B84EB01 || out_valid !== 1'b1) begin
            errors++; $display("FAIL b2b_first: got %h/%b want 8B84EB01/1", outputWord, out_valid);
        end
        @(posedge clk) #1;
        in_valid = 1'b0;
        checks++;
        if (outputWord !== 32'h52386BE5 || out_valid !== 1'b1) begin
            errors++; $display("FAIL b2b_second: got %h/%b want 52386BE5/1", outputWord, out_valid);
        end
    endtask

    task automatic test_rcon_sweep();
        logic [31:0] exp_tab [10] = '{32'h62636363, 32'h61636363, 32'h67636363, 32'h6B636363,
                                      32'h73636363, 32'h43636363, 32'h23636363, 32'hE3636363,
                                      32'h78636363, 32'h55636363};
        @(negedge clk);
        for (int r = 0; r < 10; r++) begin
            in_valid = 1'b1; inputWord = 32'h00000000; count = 4'(r);
            @(posedge clk) #1;
            checks++;
            if (outputWord !== exp_tab[r] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL rcon_sweep[%0d]: got %h/%b want %h/1", r, outputWord, out_valid, exp_tab[r]);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_out_of_range();
        logic [3:0] cnts [2] = '{4'd10, 4'd15};
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; inputWord = 32'h00000000; count = cnts[i];
            @(posedge clk) #1;
            checks++;
            if (outputWord !== 32'h63636363 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL out_of_range[%0d]: got %h/%b want 63636363/1", cnts[i], outputWord, out_valid);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] exp_word = outputWord === 32'hxxxxxxxx ? 32'h0 : 32'h63636363;
        logic        exp_valid;
        // previous test left 63636363 registered
        exp_word = 32'h63636363;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            inputWord = $urandom();
            count     = 4'($urandom_range(0, 15));
            exp_valid = in_valid;
            if (in_valid) exp_word = g_ref(inputWord, int'(count));
            @(posedge clk) #1;
            checks++;
            if (outputWord !== exp_word || out_valid !== exp_valid) begin
                errors++;
                $display("FAIL random[%0d]: got %h/%b want %h/%b", i, outputWord, out_valid, exp_word, exp_valid);
            end
        end
        @(negedge clk) in_valid = 1'b0;
    endtask

    task automatic test_reset_during_activity();
        @(negedge clk);
        in_valid = 1'b1; inputWord = 32'h09CF4F3C; count = 4'd0;
        @(posedge clk) #1;
        checks++;
        if (outputWord !== 32'h8B84EB01) begin
            errors++; $display("FAIL rst_act_preload: got %h want 8B84EB01", outputWord);
        end
        @(negedge clk);
        in_valid = 1'b1; inputWord = 32'h92BEB46D; count = 4'd0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (outputWord !== 32'h00000000 || out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_act_async: got %h/%b want 00000000/0", outputWord, out_valid);
        end
        @(posedge clk) #1;
        checks++;
        if (outputWord !== 32'h00000000 || out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_act_discard: got %h/%b want 00000000/0", outputWord, out_valid);
        end
        @(negedge clk) rst = 1'b0;
        @(posedge clk) #1;
        in_valid = 1'b0;
        checks++;
        if (outputWord !== 32'hAF8D3C4F || out_valid !== 1'b1) begin
            errors++; $display("FAIL rst_act_reissue: got %h/%b want AF8D3C4F/1", outputWord, out_valid);
        end
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; inputWord = 32'h0; count = 4'd0;
        for (int i = 0; i < 256; i++) model_sbox[i] = sbox_math(8'(i));
        test_reset();
        test_single();
        test_back_to_back();
        test_rcon_sweep();
        test_out_of_range();
        test_random();
        test_reset_during_activity();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
